// File: rtl/dmem_arb_pkg.sv
// Shared types and address map for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RESP,
    ERR
  } state_t;

  localparam int unsigned NUM_BANK_BASES = 3;
  localparam logic [31:0] BANK0_BASE     = 32'h0000_0000;
  localparam logic [31:0] BANK1_BASE     = 32'h0001_0000;
  localparam logic [31:0] BANK2_BASE     = 32'h0002_0000;
  localparam logic [31:0] BANK_SPAN      = 32'h0001_0000;

  // An address is mapped when its 64K-aligned base matches one of the first
  // bank_count bank bases; this implies addr[31:18]==0 and addr[17:16]<bank_count.
  function automatic logic addr_mapped(input logic [31:0] addr,
                                       input int unsigned bank_count);
    logic [31:0] base;
    logic [31:0] bases [NUM_BANK_BASES];
    logic        hit;
    base     = addr & ~(BANK_SPAN - 32'd1);
    bases[0] = BANK0_BASE;
    bases[1] = BANK1_BASE;
    bases[2] = BANK2_BASE;
    hit      = 1'b0;
    for (int unsigned b = 0; b < NUM_BANK_BASES; b++) begin
      if ((b < bank_count) && (base == bases[b])) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant advances only on an enabled grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant;

  // Grant a lone requester outright; on contention favour the one not served last.
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Remember which requester won the most recent enabled arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (en && (|req)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for single-word accesses to the banked
// data memory: latches the winner's operands, strobes writes, waits out the
// read latency and returns data with a one-cycle ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned BANK_COUNT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [1:0]        gnt_q;

  logic [1:0]        grant;
  logic              arb_en;
  logic              sel;
  logic              sel_we;
  logic              sel_mapped;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign arb_en = (state_q == IDLE);

  rr_arbiter2 u_arb (
    .clk   (CLK),
    .rst   (RST),
    .req   (req_i),
    .en    (arb_en),
    .grant (grant)
  );

  // Steer the winning requester's operands toward the latch.
  always_comb begin
    sel        = grant[1];
    sel_addr   = sel ? addr1_i  : addr0_i;
    sel_wdata  = sel ? wdata1_i : wdata0_i;
    sel_we     = sel ? we_i[1]  : we_i[0];
    sel_mapped = addr_mapped(32'(sel_addr), BANK_COUNT);
  end

  // Next-state selection for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          if (!sel_mapped) begin
            state_d = ERR;
          end else if (sel_we) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = (cnt_q == CNT_LAST) ? RESP : RD;
      WR:      state_d = IDLE;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, read-latency counter and operand latch; operands freeze at grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == RD) ? cnt_q + 1'b1 : '0;
      if ((state_q == IDLE) && (|req_i)) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        we_q    <= sel_we;
        gnt_q   <= grant;
      end
    end
  end

  // Per-state outputs: ack goes to the latched winner, data only while responding.
  always_comb begin
    ack_o      = '0;
    err_o      = 1'b0;
    rdata_o    = '0;
    mem_wren_o = 1'b0;
    case (state_q)
      WR: begin
        mem_wren_o = we_q;
        ack_o      = gnt_q;
      end
      RESP: begin
        ack_o   = gnt_q;
        rdata_o = mem_data_i;
      end
      ERR: begin
        ack_o = gnt_q;
        err_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_address_o = addr_q;
  assign mem_data_o    = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural two-cycle-latency memory.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [1:0]  req_i = '0;
  logic [1:0]  we_i = '0;
  logic [31:0] addr0_i = '0;
  logic [31:0] addr1_i = '0;
  logic [31:0] wdata0_i = '0;
  logic [31:0] wdata1_i = '0;
  logic [1:0]  ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        mem_wren_o;
  logic [31:0] mem_data_i;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .READ_LAT   (2),
    .BANK_COUNT (3)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_i         (req_i),
    .we_i          (we_i),
    .addr0_i       (addr0_i),
    .addr1_i       (addr1_i),
    .wdata0_i      (wdata0_i),
    .wdata1_i      (wdata1_i),
    .ack_o         (ack_o),
    .err_o         (err_o),
    .rdata_o       (rdata_o),
    .mem_address_o (mem_address_o),
    .mem_data_o    (mem_data_o),
    .mem_wren_o    (mem_wren_o),
    .mem_data_i    (mem_data_i)
  );

  // Memory model: write on strobe, read data valid two edges after the address.
  logic [31:0] mem [0:262143];
  logic [31:0] rd1, rd2;
  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = '0;
    rd1 = '0;
    rd2 = '0;
  end
  always @(posedge CLK) begin
    if (mem_wren_o === 1'b1) mem[mem_address_o[17:0]] <= mem_data_o;
    rd1 <= mem[mem_address_o[17:0]];
    rd2 <= rd1;
  end
  assign mem_data_i = rd2;

  // Protocol monitors sampled mid-cycle.
  logic        mon_en = 1'b0;
  int          wren_cnt = 0;
  int          ack_cnt = 0;
  int          onehot_viol = 0;
  int          err_viol = 0;
  int          rdata_viol = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (mem_wren_o === 1'b1) begin
        wren_cnt     <= wren_cnt + 1;
        last_wr_addr <= mem_address_o;
        last_wr_data <= mem_data_o;
      end
      if (ack_o !== 2'b00) ack_cnt <= ack_cnt + 1;
      if (ack_o === 2'b11) onehot_viol <= onehot_viol + 1;
      if ((err_o === 1'b1) && (ack_o === 2'b00)) err_viol <= err_viol + 1;
      if ((ack_o === 2'b00) && (rdata_o !== 32'h0)) rdata_viol <= rdata_viol + 1;
    end
  end

  task automatic cyc_start();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    req_i = '0;
    we_i = '0;
    cyc_start();
    cyc_start();
    RST = 1'b0;
  endtask

  // One transaction from a cycle start; latency counts the request cycle as 1.
  task automatic do_xfer(input int r, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, output int lat,
                         output logic [1:0] ack_v, output logic err_v,
                         output logic [31:0] rd_v);
    lat = -1;
    ack_v = '0;
    err_v = 1'b0;
    rd_v = '0;
    if (r == 0) begin
      addr0_i = addr;
      wdata0_i = data;
    end else begin
      addr1_i = addr;
      wdata1_i = data;
    end
    we_i[r] = we;
    req_i[r] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (ack_o[r] === 1'b1) begin
        lat = c;
        ack_v = ack_o;
        err_v = err_o;
        rd_v = rdata_o;
        break;
      end
      cyc_start();
    end
    if (lat >= 0) cyc_start();
    req_i[r] = 1'b0;
    we_i[r] = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc_start();
    cyc_start();
    @(negedge CLK);
    checks++;
    if ({ack_o, err_o, mem_wren_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ack/err/wren=%b required 0000", {ack_o, err_o, mem_wren_o});
    end
    checks++;
    if ({rdata_o, mem_address_o, mem_data_o} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required all 0",
               rdata_o, mem_address_o, mem_data_o);
    end
    cyc_start();
    RST = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_write_basic();
    int lat;
    logic [1:0] ack_v;
    logic err_v;
    logic [31:0] rd_v;
    int w0;
    w0 = wren_cnt;
    do_xfer(0, 1'b1, 32'h00005, 32'h5, lat, ack_v, err_v, rd_v);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL wr_latency: got %0d required 2", lat); end
    checks++;
    if (ack_v !== 2'b01) begin failures++; $display("FAIL wr_ack: got %b required 01", ack_v); end
    checks++;
    if (err_v !== 1'b0) begin failures++; $display("FAIL wr_err: got %b required 0", err_v); end
    checks++;
    if (wren_cnt - w0 != 1) begin
      failures++; $display("FAIL wr_strobe_len: got %0d cycles required 1", wren_cnt - w0);
    end
    checks++;
    if ((last_wr_addr !== 32'h5) || (last_wr_data !== 32'h5)) begin
      failures++;
      $display("FAIL wr_operands: addr=%h data=%h required 00000005/00000005",
               last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_readback_banks();
    int lat;
    logic [1:0] ack_v;
    logic err_v;
    logic [31:0] rd_v;
    logic [31:0] a;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 15; i++) begin
        a = (32'(b) << 16) | 32'(i);
        do_xfer(0, 1'b1, a, 32'(i), lat, ack_v, err_v, rd_v);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL rb_wr_latency @%h: got %0d required 2", a, lat); end
      end
    end
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 15; i++) begin
        a = (32'(b) << 16) | 32'(i);
        do_xfer(0, 1'b0, a, 32'h0, lat, ack_v, err_v, rd_v);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL rb_rd_latency @%h: got %0d required 4", a, lat); end
        checks++;
        if (rd_v !== 32'(i)) begin failures++; $display("FAIL rb_rdata @%h: got %h required %h", a, rd_v, 32'(i)); end
        checks++;
        if (err_v !== 1'b0) begin failures++; $display("FAIL rb_err @%h: got %b required 0", a, err_v); end
      end
    end
  endtask

  task automatic test_contention();
    int n;
    int order [6];
    logic [31:0] data [6];
    logic [1:0] drop;
    apply_reset();
    addr0_i = 32'h00001;
    addr1_i = 32'h10002;
    we_i = 2'b00;
    req_i = 2'b11;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge CLK);
      drop = ack_o;
      if (ack_o !== 2'b00) begin
        order[n] = ack_o[1] ? 1 : 0;
        data[n] = rdata_o;
        n++;
      end
      cyc_start();
      req_i = req_i & ~drop;
    end
    checks++;
    if (n != 2) begin failures++; $display("FAIL cont_pair_count: got %0d acks required 2", n); end
    checks++;
    if ((order[0] != 0) || (data[0] !== 32'h1)) begin
      failures++; $display("FAIL cont_first: req%0d data=%h required req0 data=00000001", order[0], data[0]);
    end
    checks++;
    if ((order[1] != 1) || (data[1] !== 32'h2)) begin
      failures++; $display("FAIL cont_second: req%0d data=%h required req1 data=00000002", order[1], data[1]);
    end
    req_i = 2'b11;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge CLK);
      if (ack_o !== 2'b00) begin
        order[n] = ack_o[1] ? 1 : 0;
        data[n] = rdata_o;
        n++;
      end
      cyc_start();
    end
    req_i = 2'b00;
    checks++;
    if (n != 6) begin failures++; $display("FAIL cont_run_count: got %0d acks required 6", n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (order[k] != (k % 2)) begin
        failures++; $display("FAIL cont_alternate[%0d]: got req%0d required req%0d", k, order[k], k % 2);
      end
    end
  endtask

  task automatic test_unmapped();
    int lat;
    logic [1:0] ack_v;
    logic err_v;
    logic [31:0] rd_v;
    int w0;
    w0 = wren_cnt;
    do_xfer(1, 1'b0, 32'h30000, 32'h0, lat, ack_v, err_v, rd_v);
    checks++;
    if ((lat != 2) || (ack_v !== 2'b10) || (err_v !== 1'b1)) begin
      failures++; $display("FAIL unmap_rd: lat=%0d ack=%b err=%b required 2/10/1", lat, ack_v, err_v);
    end
    do_xfer(1, 1'b1, 32'h40000, 32'hDEAD, lat, ack_v, err_v, rd_v);
    checks++;
    if ((lat != 2) || (ack_v !== 2'b10) || (err_v !== 1'b1)) begin
      failures++; $display("FAIL unmap_wr: lat=%0d ack=%b err=%b required 2/10/1", lat, ack_v, err_v);
    end
    checks++;
    if (wren_cnt != w0) begin failures++; $display("FAIL unmap_wren: got %0d strobes required 0", wren_cnt - w0); end
    do_xfer(0, 1'b0, 32'h00000, 32'h0, lat, ack_v, err_v, rd_v);
    checks++;
    if ((rd_v !== 32'h0) || (err_v !== 1'b0) || (lat != 4)) begin
      failures++; $display("FAIL unmap_readback: data=%h err=%b lat=%0d required 0/0/4", rd_v, err_v, lat);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat;
    logic [1:0] ack_v;
    logic err_v;
    logic [31:0] rd_v;
    int a0;
    int w0;
    do_xfer(0, 1'b1, 32'h10003, 32'h10003, lat, ack_v, err_v, rd_v);
    a0 = ack_cnt;
    w0 = wren_cnt;
    addr0_i = 32'h20004;
    we_i = 2'b00;
    req_i = 2'b01;
    cyc_start();
    cyc_start();
    RST = 1'b1;
    req_i = 2'b00;
    cyc_start();
    RST = 1'b0;
    for (int c = 0; c < 6; c++) cyc_start();
    checks++;
    if (ack_cnt != a0) begin failures++; $display("FAIL rst_abort_ack: got %0d acks required 0", ack_cnt - a0); end
    checks++;
    if (wren_cnt != w0) begin failures++; $display("FAIL rst_abort_wren: got %0d strobes required 0", wren_cnt - w0); end
    do_xfer(0, 1'b0, 32'h10003, 32'h0, lat, ack_v, err_v, rd_v);
    checks++;
    if ((rd_v !== 32'h10003) || (lat != 4) || (ack_v !== 2'b01)) begin
      failures++; $display("FAIL rst_next_read: data=%h lat=%0d ack=%b required 00010003/4/01", rd_v, lat, ack_v);
    end
  endtask

  task automatic test_operand_hold();
    int lat;
    logic [1:0] ack_v;
    logic err_v;
    logic [31:0] rd_v;
    addr0_i = 32'h20007;
    wdata0_i = 32'hA5A5;
    we_i = 2'b01;
    req_i = 2'b01;
    cyc_start();
    addr0_i = 32'h2000B;
    wdata0_i = 32'h5A5A;
    @(negedge CLK);
    checks++;
    if ((mem_wren_o !== 1'b1) || (mem_address_o !== 32'h20007) || (mem_data_o !== 32'hA5A5) || (ack_o !== 2'b01)) begin
      failures++;
      $display("FAIL hold_wr: wren=%b addr=%h data=%h ack=%b required 1/00020007/0000a5a5/01",
               mem_wren_o, mem_address_o, mem_data_o, ack_o);
    end
    cyc_start();
    req_i = 2'b00;
    we_i = 2'b00;
    do_xfer(0, 1'b0, 32'h20007, 32'h0, lat, ack_v, err_v, rd_v);
    checks++;
    if (rd_v !== 32'hA5A5) begin failures++; $display("FAIL hold_rb_orig: got %h required 0000a5a5", rd_v); end
    do_xfer(0, 1'b0, 32'h2000B, 32'h0, lat, ack_v, err_v, rd_v);
    checks++;
    if (rd_v !== 32'hB) begin failures++; $display("FAIL hold_rb_other: got %h required 0000000b", rd_v); end
  endtask

  task automatic test_protocol();
    checks++;
    if (onehot_viol != 0) begin failures++; $display("FAIL ack_onehot: got %0d dual acks required 0", onehot_viol); end
    checks++;
    if (err_viol != 0) begin failures++; $display("FAIL err_without_ack: got %0d required 0", err_viol); end
    checks++;
    if (rdata_viol != 0) begin failures++; $display("FAIL rdata_idle_zero: got %0d nonzero cycles required 0", rdata_viol); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_readback_banks();
    test_contention();
    test_unmapped();
    test_reset_mid_read();
    test_operand_hold();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
